// File: rtl/fifo_pkg.sv
// fifo_pkg: shared asynchronous FIFO constants and Gray/binary pointer conversion helpers.
package fifo_pkg;
  localparam int FIFO_DEPTH_BIT = 4;
  localparam int PTR_W = FIFO_DEPTH_BIT + 1;
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) b = b ^ (g >> i);
    return b;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop clock-domain-crossing synchronizer with async active-low reset to zero.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] meta_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      q_o    <= '0;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end
endmodule

// File: rtl/read_empty.sv
// read_empty: async FIFO read-side pointers, empty flag and fill level.
// Almost-empty flag is built only when READ_ALMOST_EMPTY_EN is defined.
module read_empty
  import fifo_pkg::*;
#(
  parameter int FIFO_DEPTH_BIT  = fifo_pkg::FIFO_DEPTH_BIT,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                      r_clk,
  input  logic                      r_rst_n,
  input  logic                      r_en,
  input  logic [FIFO_DEPTH_BIT:0]   write_addr_gray,
  output logic [FIFO_DEPTH_BIT-1:0] read_addr,
  output logic [FIFO_DEPTH_BIT:0]   read_addr_gray,
  output logic                      flag_empty,
  output logic [FIFO_DEPTH_BIT:0]   r_level,
  output logic                      flag_almost_empty
);
  localparam int PW = FIFO_DEPTH_BIT + 1;
  if (ALMOST_EMPTY_TH < 0 || ALMOST_EMPTY_TH > (1 << FIFO_DEPTH_BIT)) begin : g_bad_th
    $error("ALMOST_EMPTY_TH out of range");
  end
  logic [PW-1:0] wgray_sync, wbin_sync;
  logic [PW-1:0] rbin_q, rbin_d, rgray_d, level_d;
  logic          empty_d, rd_ok;
  sync_2ff #(.W(PW)) u_wsync (
    .clk_i (r_clk),
    .rst_ni(r_rst_n),
    .d_i   (write_addr_gray),
    .q_o   (wgray_sync)
  );
  // A read while empty is dropped, so the pointer can never pass the write pointer.
  assign rd_ok     = r_en & ~flag_empty;
  assign rbin_d    = rbin_q + PW'(rd_ok);
  assign rgray_d   = PW'(bin2gray(32'(rbin_d)));
  assign wbin_sync = PW'(gray2bin(32'(wgray_sync)));
  assign empty_d   = (rgray_d == wgray_sync);
  assign level_d   = wbin_sync - rbin_d;
  assign read_addr = rbin_q[FIFO_DEPTH_BIT-1:0];
  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      rbin_q         <= '0;
      read_addr_gray <= '0;
      flag_empty     <= 1'b1;
      r_level        <= '0;
    end else begin
      rbin_q         <= rbin_d;
      read_addr_gray <= rgray_d;
      flag_empty     <= empty_d;
      r_level        <= level_d;
    end
  end
`ifdef READ_ALMOST_EMPTY_EN
  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) flag_almost_empty <= 1'b1;
    else flag_almost_empty <= (level_d <= PW'(ALMOST_EMPTY_TH));
  end
`else
  assign flag_almost_empty = 1'b0;
`endif
endmodule

// File: tb/tb_read_empty.sv
// tb_read_empty: directed self-checking bench for read_empty (FIFO_DEPTH_BIT=4, ALMOST_EMPTY_TH=2).
module tb_read_empty;
`ifdef READ_ALMOST_EMPTY_EN
  localparam bit AE_ON = 1'b1;
`else
  localparam bit AE_ON = 1'b0;
`endif
  logic       r_clk = 1'b0;
  logic       r_rst_n = 1'b0;
  logic       r_en = 1'b0;
  logic [4:0] write_addr_gray = '0;
  logic [3:0] read_addr;
  logic [4:0] read_addr_gray;
  logic       flag_empty;
  logic [4:0] r_level;
  logic       flag_almost_empty;
  int checks = 0;
  int failures = 0;

  read_empty #(.FIFO_DEPTH_BIT(4), .ALMOST_EMPTY_TH(2)) dut (
    .r_clk            (r_clk),
    .r_rst_n          (r_rst_n),
    .r_en             (r_en),
    .write_addr_gray  (write_addr_gray),
    .read_addr        (read_addr),
    .read_addr_gray   (read_addr_gray),
    .flag_empty       (flag_empty),
    .r_level          (r_level),
    .flag_almost_empty(flag_almost_empty)
  );

  always #5 r_clk = ~r_clk;

  function automatic logic [4:0] g(input int b);
    logic [4:0] x;
    x = 5'(b);
    return x ^ (x >> 1);
  endfunction

  task automatic step();
    @(posedge r_clk);
    #1;
  endtask

  task automatic test_reset();
    r_rst_n = 1'b0; r_en = 1'b1; write_addr_gray = 5'b00110;
    step(); step();
    checks++; if (flag_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0b exp=1", flag_empty); end
    checks++; if (read_addr !== 4'd0) begin failures++; $display("FAIL reset_raddr got=%0d exp=0", read_addr); end
    checks++; if (read_addr_gray !== 5'd0) begin failures++; $display("FAIL reset_rgray got=%b exp=00000", read_addr_gray); end
    checks++; if (r_level !== 5'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", r_level); end
    checks++; if (flag_almost_empty !== AE_ON) begin failures++; $display("FAIL reset_ae got=%0b exp=%0b", flag_almost_empty, AE_ON); end
    r_en = 1'b0; write_addr_gray = '0;
    step();
    r_rst_n = 1'b1;
    step();
  endtask

  task automatic test_empty_latency();
    write_addr_gray = 5'b00010;
    for (int e = 1; e <= 3; e++) begin
      step();
      checks++; if (flag_empty !== (e < 3)) begin failures++; $display("FAIL lat_empty edge=%0d got=%0b exp=%0b", e, flag_empty, e < 3); end
    end
    checks++; if (r_level !== 5'd3) begin failures++; $display("FAIL lat_level got=%0d exp=3", r_level); end
    checks++; if (flag_almost_empty !== 1'b0) begin failures++; $display("FAIL lat_ae got=%0b exp=0", flag_almost_empty); end
  endtask

  task automatic test_drain();
    r_en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++; if (read_addr !== 4'((k > 3) ? 3 : k)) begin failures++; $display("FAIL drain_raddr k=%0d got=%0d exp=%0d", k, read_addr, (k > 3) ? 3 : k); end
      checks++; if (read_addr_gray !== g((k > 3) ? 3 : k)) begin failures++; $display("FAIL drain_rgray k=%0d got=%b exp=%b", k, read_addr_gray, g((k > 3) ? 3 : k)); end
      checks++; if (flag_empty !== (k >= 3)) begin failures++; $display("FAIL drain_empty k=%0d got=%0b exp=%0b", k, flag_empty, k >= 3); end
      checks++; if (r_level !== 5'((k > 3) ? 0 : 3 - k)) begin failures++; $display("FAIL drain_level k=%0d got=%0d", k, r_level); end
      checks++; if (flag_almost_empty !== AE_ON) begin failures++; $display("FAIL drain_ae k=%0d got=%0b exp=%0b", k, flag_almost_empty, AE_ON); end
    end
    r_en = 1'b0;
  endtask

  // Read n entries back to back starting from binary read pointer r0.
  task automatic read_run(input int r0, input int n);
    r_en = 1'b1;
    for (int k = 1; k <= n; k++) begin
      step();
      checks++; if (read_addr_gray !== g(r0 + k)) begin failures++; $display("FAIL run_rgray ptr=%0d got=%b exp=%b", r0 + k, read_addr_gray, g(r0 + k)); end
      checks++; if (read_addr !== 4'((r0 + k) % 16)) begin failures++; $display("FAIL run_raddr ptr=%0d got=%0d exp=%0d", r0 + k, read_addr, (r0 + k) % 16); end
      checks++; if (flag_empty !== (k == n)) begin failures++; $display("FAIL run_empty ptr=%0d got=%0b exp=%0b", r0 + k, flag_empty, k == n); end
      checks++; if (r_level !== 5'(n - k)) begin failures++; $display("FAIL run_level ptr=%0d got=%0d exp=%0d", r0 + k, r_level, n - k); end
      checks++; if (flag_almost_empty !== (AE_ON && (n - k) <= 2)) begin failures++; $display("FAIL run_ae ptr=%0d got=%0b", r0 + k, flag_almost_empty); end
    end
    r_en = 1'b0;
  endtask

  task automatic test_wrap();
    write_addr_gray = g(18);
    step(); step(); step();
    checks++; if (r_level !== 5'd15 || flag_empty !== 1'b0) begin failures++; $display("FAIL wrap_fill1 level=%0d empty=%0b exp=15/0", r_level, flag_empty); end
    read_run(3, 15);
    write_addr_gray = g(33);
    step(); step(); step();
    checks++; if (r_level !== 5'd15 || flag_empty !== 1'b0) begin failures++; $display("FAIL wrap_fill2 level=%0d empty=%0b exp=15/0", r_level, flag_empty); end
    read_run(18, 15);
  endtask

  task automatic test_full_level();
    r_rst_n = 1'b0; write_addr_gray = 5'b11000;
    step();
    r_rst_n = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      step();
      checks++; if (flag_empty !== (e < 3)) begin failures++; $display("FAIL full_empty edge=%0d got=%0b exp=%0b", e, flag_empty, e < 3); end
    end
    checks++; if (r_level !== 5'd16) begin failures++; $display("FAIL full_level got=%0d exp=16", r_level); end
    checks++; if (read_addr !== 4'd0) begin failures++; $display("FAIL full_raddr got=%0d exp=0", read_addr); end
    checks++; if (flag_almost_empty !== 1'b0) begin failures++; $display("FAIL full_ae got=%0b exp=0", flag_almost_empty); end
    read_run(0, 16);
  endtask

  task automatic test_mid_reset();
    write_addr_gray = g(21);
    step(); step(); step();
    checks++; if (r_level !== 5'd5) begin failures++; $display("FAIL mid_level_pre got=%0d exp=5", r_level); end
    r_en = 1'b1;
    step();
    checks++; if (read_addr !== 4'd1) begin failures++; $display("FAIL mid_raddr_pre got=%0d exp=1", read_addr); end
    #3 r_rst_n = 1'b0;
    #1;
    checks++; if (read_addr !== 4'd0 || read_addr_gray !== 5'd0) begin failures++; $display("FAIL mid_ptrs got=%0d/%b exp=0/00000", read_addr, read_addr_gray); end
    checks++; if (flag_empty !== 1'b1 || r_level !== 5'd0) begin failures++; $display("FAIL mid_flags empty=%0b level=%0d exp=1/0", flag_empty, r_level); end
    checks++; if (flag_almost_empty !== AE_ON) begin failures++; $display("FAIL mid_ae got=%0b exp=%0b", flag_almost_empty, AE_ON); end
    step();
    r_en = 1'b0; write_addr_gray = '0;
    r_rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_empty_latency();
    test_drain();
    test_wrap();
    test_full_level();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/read_empty.md
# read_empty

Read-side pointer and empty-flag generator for the interface asynchronous FIFO; counterpart of `write_full`. It lives in the read clock domain and brings the write pointer's Gray code across the domain boundary with a two-flop synchronizer. It advances the binary and Gray read pointers on accepted reads and produces a registered empty flag, a fill level and an optional almost-empty flag. It drives the RAM read address and returns its Gray pointer to the write domain.

## Interface
- `FIFO_DEPTH_BIT`, 4: log2 of FIFO depth; pointers are FIFO_DEPTH_BIT+1 bits wide.
- `ALMOST_EMPTY_TH`, 2: level at or below which almost-empty asserts; valid range 0..2^FIFO_DEPTH_BIT.
- `r_clk`  in  1  read-domain clock.
- `r_rst_n`  in  1  asynchronous, active-low reset.
- `r_en`  in  1  read request.
- `write_addr_gray`  in  FIFO_DEPTH_BIT+1  write pointer, Gray code, from the write domain (unsynchronized).
- `read_addr`  out  FIFO_DEPTH_BIT  RAM read address, which is the low bits of the binary read pointer.
- `read_addr_gray`  out  FIFO_DEPTH_BIT+1  registered Gray read pointer, sent to the write domain.
- `flag_empty`  out  1  FIFO empty; registered.
- `r_level`  out  FIFO_DEPTH_BIT+1  entries available, 0..2^FIFO_DEPTH_BIT; registered.
- `flag_almost_empty`  out  1  level ≤ ALMOST_EMPTY_TH; registered.

## Operation
- Synchronizer: 2-flop chain on `write_addr_gray` produces `wgray_sync`.
- Accepted read: `rd_ok = r_en & ~flag_empty`. A read while empty is ignored and changes no state.
- Next-state logic:
  - `rbin_next = rbin + rd_ok`, modulo 2^(FIFO_DEPTH_BIT+1).
  - `rgray_next = (rbin_next >> 1) ^ rbin_next`.
- Empty: `empty_next = (rgray_next == wgray_sync)`, with a full-width compare including the wrap bit.
- Level: `wbin_sync = gray2bin(wgray_sync)` and `level_next = wbin_sync - rbin_next`, modulo 2^(FIFO_DEPTH_BIT+1). Level 2^FIFO_DEPTH_BIT is the full case: MSB differs and the low bits are equal.
- Registers updated every edge: `rbin`, `read_addr_gray` ← `rgray_next`, `flag_empty` ← `empty_next`, `r_level` ← `level_next`, and `flag_almost_empty` ← `(level_next <= ALMOST_EMPTY_TH)`.
- `read_addr = rbin[FIFO_DEPTH_BIT-1:0]`.
- Reset values: `rbin`=0, `read_addr`=0, `read_addr_gray`=0, synchronizer stages=0, `flag_empty`=1, `r_level`=0, `flag_almost_empty`=1.
- Wrap-around: after 2^(FIFO_DEPTH_BIT+1) reads, pointers return to 0. The MSB toggles every 2^FIFO_DEPTH_BIT reads.
- Reset mid-operation: all state clears immediately on the fall of `r_rst_n`, regardless of `r_en`. The write side is reset together with this block, per system rules.

## Timing
- Read latency: `read_addr` presents the current entry. An accepted read at edge N advances `read_addr`/`read_addr_gray` at edge N.
- Last-entry read: when `rd_ok` consumes the final entry at edge N, `flag_empty`=1 from edge N, so there is never a read past empty.
- Empty deassert: a write pointer change is visible in `wgray_sync` after 2 `r_clk` edges. `flag_empty` falls on the 3rd edge, making it pessimistic by up to 3 cycles.
- Simultaneous write-pointer change and read: the result uses the post-read pointer against the synchronized write pointer. No special case applies.
- `r_level` and `flag_almost_empty` have the same 3-edge lag as `flag_empty`.

## Configuration
- `READ_ALMOST_EMPTY_EN`
  - Defined: the almost-empty compare and register are built as above.
  - Undefined: `flag_almost_empty` is tied to 0, no compare logic is generated, and the port is still present.
  - `r_level` is always built.

## Structure
- Shared package `fifo_pkg`:
  - default `FIFO_DEPTH_BIT`;
  - pointer-width constant;
  - `bin2gray`/`gray2bin` functions, shared with `write_full`.
- Sub-module `sync_2ff`: parameterized-width two-flop synchronizer with async active-low reset to 0. It is reused for the read pointer in the write domain.

## Test plan
Cases assume FIFO_DEPTH_BIT=4 and ALMOST_EMPTY_TH=2 unless stated.
- **Reset:** hold `r_rst_n`=0 with `r_en`=1 and `write_addr_gray`=5'b00110 → `flag_empty`=1, `read_addr`=0, `read_addr_gray`=0, `r_level`=0, `flag_almost_empty`=1.
- **Empty deassert latency:** from reset, `write_addr_gray`=gray(3)=5'b00010 → `flag_empty`=0 and `r_level`=3 exactly on the 3rd `r_clk` edge.
- **Drain to empty:**
  - From level 3, hold `r_en`=1 → `read_addr` steps 1,2,3.
  - `flag_almost_empty` is 1 from level 2.
  - `flag_empty`=1 at the edge of the 3rd read.
  - Further `r_en` leaves `read_addr`=3.
- **Wrap:**
  - Write side advances in step to pointer 32 (gray 0) while reads stay ≥1 behind.
  - Read pointer passes 15→16: `read_addr_gray` 5'b01000→5'b11000.
  - Pointer 31→0: `read_addr_gray` returns to 0 and `flag_empty` is correct throughout.
- **Full level:** `write_addr_gray`=gray(16)=5'b11000 with the read pointer at 0 → `r_level`=16 and `flag_empty`=0.
- **Macro off:** build without `READ_ALMOST_EMPTY_EN`, then repeat the drain test → `flag_almost_empty` is constantly 0 and all other outputs are identical.
